// File: rtl/arm_pkg.sv
// arm_pkg: shared state encodings, opcodes and opcode-class helpers for the ARM control FSM
package arm_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_UNDEF  = 3'd5
  } state_t;
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
  function automatic logic is_test(input logic [3:0] op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction
  function automatic logic is_logical(input logic [3:0] op);
    return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN};
  endfunction
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: synchronises the step switch and emits a one-cycle rising-edge pulse
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);
  logic [2:0] sync_q;
  // Reset to all-ones so a switch held high through reset is seen as already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else sync_q <= {sync_q[1:0], sig_i};
  end
  assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multi-cycle control unit for ARM data-processing instructions, owns NZCV
module arm_ctrl_fsm
  import arm_pkg::*;
#(
  parameter logic [3:0] NZCV_RST = 4'b0000,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             run,
  input  logic [27:0]      ir,
  input  logic             flag,
  input  logic [3:0]       alu_nzcv,
  input  logic             shift_c,
  output logic             write_ir,
  output logic             write_pc,
  output logic [3:0]       nzcv,
  output logic [3:0]       alu_op,
  output logic             imm_sel,
  output logic [3:0]       rn_addr,
  output logic [3:0]       rd_addr,
  output logic [3:0]       rm_addr,
  output logic             write_res,
  output logic             write_reg,
  output logic             undef,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] skipped_cnt
);
  state_t state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic undef_q, undef_d;
  logic [CNT_W-1:0] ret_q, ret_d, skp_q, skp_d;
  logic step_p, busy_dp;
  logic [3:0] op;
  logic unused_ir;
  assign op = ir[24:21];
  assign unused_ir = ^ir[11:4];
  edge_detect u_step (.clk(clk), .rst_n(rst_n), .sig_i(step), .pulse_o(step_p));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nzcv_q  <= NZCV_RST;
      undef_q <= 1'b0;
      ret_q   <= '0;
      skp_q   <= '0;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
      undef_q <= undef_d;
      ret_q   <= ret_d;
      skp_q   <= skp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    nzcv_d  = nzcv_q;
    undef_d = undef_q;
    ret_d   = ret_q;
    skp_d   = skp_q;
    case (state_q)
      S_IDLE:   state_d = (step_p || run) ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!flag) begin
          skp_d   = skp_q + CNT_W'(1);
          state_d = S_IDLE;
        end else if (ir[27:26] != 2'b00 || (is_test(op) && !ir[20])) begin
          state_d = S_UNDEF;
        end else begin
          undef_d = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        // Logical ops take C from the shifter and keep V.
        if (ir[20]) nzcv_d = is_arith(op) ? alu_nzcv :
                             is_logical(op) ? {alu_nzcv[3:2], shift_c, nzcv_q[0]} : nzcv_q;
        ret_d   = ret_q + CNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_UNDEF: begin
        undef_d = 1'b1;
        skp_d   = skp_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end
  assign busy_dp     = (state_q == S_EXEC) || (state_q == S_WB);
  assign write_ir    = state_q == S_FETCH;
  assign write_pc    = state_q == S_FETCH;
  assign write_res   = state_q == S_EXEC;
  assign write_reg   = (state_q == S_WB) && !is_test(op);
  assign alu_op      = busy_dp ? op : 4'h0;
  assign imm_sel     = busy_dp & ir[25];
  assign rn_addr     = ir[19:16];
  assign rd_addr     = ir[15:12];
  assign rm_addr     = ir[3:0];
  assign nzcv        = nzcv_q;
  assign undef       = undef_q;
  assign state       = state_q;
  assign retired_cnt = ret_q;
  assign skipped_cnt = skp_q;
endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// tb_arm_ctrl_fsm: directed scoreboard bench for the ARM control FSM
module tb_arm_ctrl_fsm;
  logic clk = 0, rst_n = 0, step = 0, run = 0, flag = 0, shift_c = 0;
  logic [27:0] ir = '0;
  logic [3:0] alu_nzcv = '0;
  logic write_ir, write_pc, imm_sel, write_res, write_reg, undef;
  logic [3:0] nzcv, alu_op, rn_addr, rd_addr, rm_addr;
  logic [2:0] state;
  logic [7:0] retired_cnt, skipped_cnt;
  int checks = 0, fails = 0;
  logic [7:0] exp_ret = 0, exp_skp = 0;
  typedef struct {
    logic [3:0] nzcv;
    int         busy;
    logic       wreg;
    logic       wres;
    logic       undef;
    logic [7:0] ret;
    logic [7:0] skp;
    logic [3:0] op;
  } exp_t;
  exp_t sb[$];

  arm_ctrl_fsm #(.NZCV_RST(4'b0000), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .ir(ir), .flag(flag),
    .alu_nzcv(alu_nzcv), .shift_c(shift_c), .write_ir(write_ir), .write_pc(write_pc),
    .nzcv(nzcv), .alu_op(alu_op), .imm_sel(imm_sel), .rn_addr(rn_addr),
    .rd_addr(rd_addr), .rm_addr(rm_addr), .write_res(write_res), .write_reg(write_reg),
    .undef(undef), .state(state), .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 executed, 1 skipped by flag, 2 undefined
  task automatic run_one(input logic [27:0] i, input logic f, input logic [3:0] a, input logic sc,
                         input logic [3:0] e_nzcv, input int kind, input logic e_wreg,
                         input logic e_undef);
    int n, busy, wir, wpc;
    logic wreg, wres;
    logic [3:0] opx;
    exp_t e, x;
    if (kind == 0) exp_ret++;
    else exp_skp++;
    e.nzcv = e_nzcv; e.busy = (kind == 0) ? 4 : (kind == 1) ? 2 : 3;
    e.wreg = e_wreg; e.wres = kind == 0; e.undef = e_undef;
    e.ret = exp_ret; e.skp = exp_skp; e.op = (kind == 0) ? i[24:21] : 4'h0;
    sb.push_back(e);
    step = 0;
    repeat (4) @(negedge clk);
    ir = i; flag = f; alu_nzcv = a; shift_c = sc; step = 1;
    n = 0;
    while (state == 3'd0 && n < 10) begin @(negedge clk); n++; end
    if (state == 3'd0) chk("start_timeout", {29'd0, state}, 32'd1);
    busy = 0; wir = 0; wpc = 0; wreg = 0; wres = 0; opx = 0;
    while (state != 3'd0 && busy < 20) begin
      busy++; wir += int'(write_ir); wpc += int'(write_pc);
      wreg |= write_reg; wres |= write_res;
      if (state == 3'd3) opx = alu_op;
      @(negedge clk);
    end
    x = sb.pop_front();
    chk("busy_cycles", busy, x.busy);
    chk("write_ir_pulses", wir, 1);
    chk("write_pc_pulses", wpc, 1);
    chk("write_reg_seen", wreg, x.wreg);
    chk("write_res_seen", wres, x.wres);
    chk("alu_op_exec", opx, x.op);
    chk("nzcv", nzcv, x.nzcv);
    chk("undef", undef, x.undef);
    chk("retired_cnt", retired_cnt, x.ret);
    chk("skipped_cnt", skipped_cnt, x.skp);
    repeat (3) @(negedge clk);
    chk("held_step_no_refire", state, 0);
    chk("alu_op_idle", alu_op, 0);
  endtask

  initial begin
    int k, pulses, last, cnt, need, wir;
    step = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    wir = 0;
    repeat (6) begin @(negedge clk); wir += int'(write_ir); end
    chk("rst_state", state, 0);
    chk("rst_nzcv", nzcv, 4'b0000);
    chk("rst_no_write_ir", wir, 0);
    chk("rst_undef", undef, 0);
    chk("rst_retired", retired_cnt, 0);

    ir = 28'h0012345;
    #1;
    chk("rn_addr", rn_addr, 4'h1);
    chk("rd_addr", rd_addr, 4'h2);
    chk("rm_addr", rm_addr, 4'h5);

    run_one(28'h0900001, 1, 4'b0110, 0, 4'b0110, 0, 1, 0);  // ADD S=1
    run_one(28'h1500000, 1, 4'b1001, 0, 4'b1001, 0, 0, 0);  // CMP S=1
    run_one(28'h0900000, 1, 4'b0001, 0, 4'b0001, 0, 1, 0);  // ADD S=1 presets V
    run_one(28'h1B00000, 1, 4'b0100, 1, 4'b0111, 0, 1, 0);  // MOV S=1: C<-shift_c, V kept
    run_one(28'h1B00000, 0, 4'b1000, 0, 4'b0111, 1, 0, 0);  // condition fails
    run_one(28'h8000000, 1, 4'b1111, 1, 4'b0111, 2, 0, 1);  // non-DP class
    run_one(28'h1400000, 1, 4'b1111, 1, 4'b0111, 2, 0, 1);  // CMP without S
    run_one(28'h0800000, 1, 4'b1111, 0, 4'b0111, 0, 1, 0);  // ADD S=0 clears undef

    step = 0; ir = 28'h0800000; flag = 1;
    repeat (4) @(negedge clk);
    run = 1; k = 0; pulses = 0; last = 0;
    while (k < 40 && pulses < 3) begin
      @(negedge clk); k++;
      if (write_ir) begin
        if (pulses > 0) chk("run_gap", k - last, 4);
        last = k; pulses++;
        if (pulses == 3) run = 0;
      end
    end
    chk("run_pulses", pulses, 3);
    k = 0;
    while (state != 3'd0 && k < 20) begin @(negedge clk); k++; end
    exp_ret += 3;
    chk("run_idle", state, 0);
    chk("run_retired", retired_cnt, exp_ret);

    need = 256 - int'(exp_ret); cnt = 0; k = 0;
    run = 1;
    while (cnt < need && k < 2000) begin
      @(negedge clk); k++;
      if (state == 3'd4) cnt++;
      if (cnt == need) run = 0;
    end
    run = 0; k = 0;
    while (state != 3'd0 && k < 20) begin @(negedge clk); k++; end
    exp_ret = 0;
    chk("wrap_count", cnt, need);
    chk("wrap_retired", retired_cnt, exp_ret);

    run = 1; k = 0;
    while (state != 3'd3 && k < 20) begin @(negedge clk); k++; end
    run = 0;
    chk("abort_reach_exec", state, 3);
    rst_n = 0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_nzcv", nzcv, 4'b0000);
    chk("abort_skipped", skipped_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
